// File: rtl/mips_stage_reg_fwd.sv
// rtl/mips_stage_reg_fwd.sv - MIPS register-read stage with register file, bypass/interlock and REG/EX register
module mips_stage_reg_fwd #(
  parameter int WIDTH    = 32,
  parameter bit FORWARD  = 1'b1,
  parameter int CNT_BITS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [31:0]         in_instruction,
  input  logic [WIDTH-1:0]    in_pcAddr,
  output logic                in_ready,
  input  logic                stall,
  input  logic                flush,
  input  logic                ex_writeEn,
  input  logic                ex_isLoad,
  input  logic [4:0]          ex_writeReg,
  input  logic [WIDTH-1:0]    ex_value,
  input  logic                mem_writeEn,
  input  logic [4:0]          mem_writeReg,
  input  logic [WIDTH-1:0]    mem_value,
  input  logic                wb_writeEn,
  input  logic [4:0]          wb_writeReg,
  input  logic [WIDTH-1:0]    wb_value,
  output logic                out_valid,
  output logic [31:0]         out_instruction,
  output logic [WIDTH-1:0]    out_pcAddr,
  output logic [WIDTH-1:0]    out_port1,
  output logic [WIDTH-1:0]    out_port2,
  output logic                out_portEq,
  output logic [CNT_BITS-1:0] stallCount
);

  logic [WIDTH-1:0] regFile [32];
  logic [1:0][4:0]  srcReg;
  logic [WIDTH-1:0] resolved [2];
  logic [1:0]       srcHaz;
  logic             hazard;

  assign srcReg[0] = in_instruction[25:21];
  assign srcReg[1] = in_instruction[20:16];

  // Later assignments override earlier ones, so the order below encodes bypass priority.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      resolved[i] = regFile[srcReg[i]];
      srcHaz[i]   = 1'b0;
      if (wb_writeEn && wb_writeReg == srcReg[i])
        resolved[i] = wb_value;
      if (FORWARD) begin
        if (mem_writeEn && mem_writeReg == srcReg[i])
          resolved[i] = mem_value;
        if (ex_writeEn && !ex_isLoad && ex_writeReg == srcReg[i])
          resolved[i] = ex_value;
        srcHaz[i] = ex_writeEn && ex_isLoad && ex_writeReg == srcReg[i];
      end else begin
        srcHaz[i] = (ex_writeEn && ex_writeReg == srcReg[i]) ||
                    (mem_writeEn && mem_writeReg == srcReg[i]);
      end
      if (srcReg[i] == 5'd0) begin
        resolved[i] = '0;
        srcHaz[i]   = 1'b0;
      end
    end
  end

  assign hazard   = in_valid && (|srcHaz);
  assign in_ready = reset && !stall && (flush || !hazard);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++)
        regFile[r] <= '0;
    end else if (wb_writeEn && wb_writeReg != 5'd0) begin
      regFile[wb_writeReg] <= wb_value;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pcAddr      <= '0;
      out_port1       <= '0;
      out_port2       <= '0;
      out_portEq      <= 1'b0;
      stallCount      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (hazard) begin
        out_valid <= 1'b0;
        if (stallCount != {CNT_BITS{1'b1}})
          stallCount <= stallCount + CNT_BITS'(1);
      end else begin
        out_valid       <= in_valid;
        out_instruction <= in_instruction;
        out_pcAddr      <= in_pcAddr;
        out_port1       <= resolved[0];
        out_port2       <= resolved[1];
        out_portEq      <= (resolved[0] == resolved[1]);
      end
    end
  end

endmodule

// File: tb/tb_mips_stage_reg_fwd.sv
// tb/tb_mips_stage_reg_fwd.sv - directed vector bench for mips_stage_reg_fwd (bypass and interlock builds)
module tb_mips_stage_reg_fwd;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt;
    logic [31:0] pc;
    logic        stl, fl;
    logic        exEn, exLd;
    logic [4:0]  exReg;
    logic [31:0] exVal;
    logic        memEn;
    logic [4:0]  memReg;
    logic [31:0] memVal;
    logic        wbEn;
    logic [4:0]  wbReg;
    logic [31:0] wbVal;
    logic        expReady, expValid;
    logic [31:0] expPc, expP1, expP2;
    logic        expEq;
    logic [15:0] expCnt;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid;
  logic [31:0] inInstruction, inPcAddr;
  logic        stall, flush;
  logic        exWriteEn, exIsLoad, memWriteEn, wbWriteEn;
  logic [4:0]  exWriteReg, memWriteReg, wbWriteReg;
  logic [31:0] exValue, memValue, wbValue;

  logic        aReady, aValid, aEq, bReady, bValid, bEq;
  logic [31:0] aInstr, aPc, aP1, aP2, bInstr, bPc, bP1, bP2;
  logic [15:0] aCnt;
  logic [1:0]  bCnt;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  mips_stage_reg_fwd #(.WIDTH(32), .FORWARD(1'b1), .CNT_BITS(16)) dutA (
    .clock(clock), .reset(reset), .in_valid(inValid), .in_instruction(inInstruction),
    .in_pcAddr(inPcAddr), .in_ready(aReady), .stall(stall), .flush(flush),
    .ex_writeEn(exWriteEn), .ex_isLoad(exIsLoad), .ex_writeReg(exWriteReg), .ex_value(exValue),
    .mem_writeEn(memWriteEn), .mem_writeReg(memWriteReg), .mem_value(memValue),
    .wb_writeEn(wbWriteEn), .wb_writeReg(wbWriteReg), .wb_value(wbValue),
    .out_valid(aValid), .out_instruction(aInstr), .out_pcAddr(aPc),
    .out_port1(aP1), .out_port2(aP2), .out_portEq(aEq), .stallCount(aCnt)
  );

  mips_stage_reg_fwd #(.WIDTH(32), .FORWARD(1'b0), .CNT_BITS(2)) dutB (
    .clock(clock), .reset(reset), .in_valid(inValid), .in_instruction(inInstruction),
    .in_pcAddr(inPcAddr), .in_ready(bReady), .stall(stall), .flush(flush),
    .ex_writeEn(exWriteEn), .ex_isLoad(exIsLoad), .ex_writeReg(exWriteReg), .ex_value(exValue),
    .mem_writeEn(memWriteEn), .mem_writeReg(memWriteReg), .mem_value(memValue),
    .wb_writeEn(wbWriteEn), .wb_writeReg(wbWriteReg), .wb_value(wbValue),
    .out_valid(bValid), .out_instruction(bInstr), .out_pcAddr(bPc),
    .out_port1(bP1), .out_port2(bP2), .out_portEq(bEq), .stallCount(bCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    inValid       = v.valid;
    inInstruction = {6'h08, v.rs, v.rt, v.pc[15:0]};
    inPcAddr      = v.pc;
    stall         = v.stl;
    flush         = v.fl;
    exWriteEn     = v.exEn;  exIsLoad = v.exLd; exWriteReg = v.exReg; exValue = v.exVal;
    memWriteEn    = v.memEn; memWriteReg = v.memReg; memValue = v.memVal;
    wbWriteEn     = v.wbEn;  wbWriteReg = v.wbReg; wbValue = v.wbVal;
  endtask

  // sel: 0 checks the bypass build, 1 the interlock build, 2 both
  task automatic applyVec(input string tag, input vec_t v, input int sel);
    drive(v);
    #1;
    if (sel != 1) chk({tag, " A in_ready"}, 32'(aReady), 32'(v.expReady));
    if (sel != 0) chk({tag, " B in_ready"}, 32'(bReady), 32'(v.expReady));
    @(posedge clock); #1;
    if (sel != 1) begin
      chk({tag, " A out_valid"}, 32'(aValid), 32'(v.expValid));
      chk({tag, " A out_pcAddr"}, aPc, v.expPc);
      chk({tag, " A out_port1"}, aP1, v.expP1);
      chk({tag, " A out_port2"}, aP2, v.expP2);
      chk({tag, " A out_portEq"}, 32'(aEq), 32'(v.expEq));
      chk({tag, " A stallCount"}, 32'(aCnt), 32'(v.expCnt));
    end
    if (sel != 0) begin
      chk({tag, " B out_valid"}, 32'(bValid), 32'(v.expValid));
      chk({tag, " B out_pcAddr"}, bPc, v.expPc);
      chk({tag, " B out_port1"}, bP1, v.expP1);
      chk({tag, " B out_port2"}, bP2, v.expP2);
      chk({tag, " B out_portEq"}, 32'(bEq), 32'(v.expEq));
      chk({tag, " B stallCount"}, 32'(bCnt), 32'(v.expCnt));
    end
  endtask

  task automatic resetCycle(input string tag);
    vec_t r;
    r = '{1'b1, 5'd9, 5'd9, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
          1'b1, 5'd9, 32'h77, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0};
    reset = 1'b0;
    applyVec(tag, r, 2);
    reset = 1'b1;
  endtask

  vec_t vecsA [14];
  vec_t vecsB [3];
  vec_t v;

  initial begin
    vecsA[0]  = '{1'b1, 5'd5, 5'd0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b1, 5'd5, 32'h1234, 1'b1, 1'b1, 32'h100, 32'h1234, 32'h0, 1'b0, 16'd0};
    vecsA[1]  = '{1'b1, 5'd5, 5'd5, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h1234, 32'h1234, 1'b1, 16'd0};
    vecsA[2]  = '{1'b1, 5'd0, 5'd5, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b1, 5'd0, 32'hFFFF, 1'b1, 1'b1, 32'h108, 32'h0, 32'h1234, 1'b0, 16'd0};
    vecsA[3]  = '{1'b1, 5'd0, 5'd0, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h10C, 32'h0, 32'h0, 1'b1, 16'd0};
    vecsA[4]  = '{1'b1, 5'd3, 5'd3, 32'h110, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB,
                  1'b1, 5'd3, 32'hC, 1'b1, 1'b1, 32'h110, 32'hA, 32'hA, 1'b1, 16'd0};
    vecsA[5]  = '{1'b1, 5'd3, 5'd0, 32'h114, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hB,
                  1'b1, 5'd3, 32'hD, 1'b1, 1'b1, 32'h114, 32'hB, 32'h0, 1'b0, 16'd0};
    vecsA[6]  = '{1'b1, 5'd0, 5'd7, 32'h118, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h114, 32'hB, 32'h0, 1'b0, 16'd1};
    vecsA[7]  = '{1'b1, 5'd0, 5'd7, 32'h118, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h55,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h118, 32'h0, 32'h55, 1'b0, 16'd1};
    vecsA[8]  = '{1'b1, 5'd3, 5'd3, 32'h11C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h11C, 32'hD, 32'hD, 1'b1, 16'd1};
    vecsA[9]  = '{1'b1, 5'd5, 5'd0, 32'h120, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h11C, 32'hD, 32'hD, 1'b1, 16'd1};
    vecsA[10] = '{1'b1, 5'd5, 5'd0, 32'h120, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h11C, 32'hD, 32'hD, 1'b1, 16'd1};
    vecsA[11] = '{1'b1, 5'd5, 5'd0, 32'h120, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h11C, 32'hD, 32'hD, 1'b1, 16'd1};
    vecsA[12] = '{1'b1, 5'd5, 5'd0, 32'h124, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h11C, 32'hD, 32'hD, 1'b1, 16'd1};
    vecsA[13] = '{1'b0, 5'd5, 5'd3, 32'h128, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h128, 32'h1234, 32'hD, 1'b0, 16'd1};

    vecsB[0]  = '{1'b1, 5'd2, 5'd0, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd1};
    vecsB[1]  = '{1'b1, 5'd2, 5'd0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22,
                  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd2};
    vecsB[2]  = '{1'b1, 5'd2, 5'd0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b1, 5'd2, 32'h22, 1'b1, 1'b1, 32'h200, 32'h22, 32'h0, 1'b0, 16'd2};

    resetCycle("reset0");
    resetCycle("reset1");

    for (int i = 0; i < 14; i++) applyVec($sformatf("fwd%0d", i), vecsA[i], 0);

    resetCycle("resetB");
    for (int i = 0; i < 3; i++) applyVec($sformatf("ilk%0d", i), vecsB[i], 1);

    // Saturation of the narrow counter, then reset in the middle of traffic.
    resetCycle("resetSat");
    for (int i = 0; i < 5; i++) begin
      v = '{1'b1, 5'd4, 5'd0, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0,
            1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, (i < 3) ? 16'(i + 1) : 16'd3};
      applyVec($sformatf("sat%0d", i), v, 1);
    end
    v = '{1'b1, 5'd4, 5'd0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
          1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 32'h300, 32'h0, 32'h0, 1'b1, 16'd3};
    applyVec("wr9", v, 1);
    resetCycle("midReset");
    v = '{1'b1, 5'd9, 5'd0, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
          1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h304, 32'h0, 32'h0, 1'b1, 16'd0};
    applyVec("cleared", v, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
